// File: rtl/eth_rt_pkg.sv
// Shared types and constants for the real-time Ethernet transmit/receive path.
// Latency: n/a (package only).
// Backpressure: n/a.
package eth_rt_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA,
      S_PAD,
      S_FCS,
      S_IPG
   } tx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   // CRC register is kept in the non-reflected domain; data bits are fed LSB first.
   localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   // Register value after a frame plus its own FCS has been clocked through.
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

   localparam int STAT_UNDERRUN = 31;
   localparam int STAT_ABORT    = 30;
   localparam int STAT_ZERO_LEN = 29;
   localparam int STAT_FCNT_LSB = 16;
   localparam int STAT_BCNT_LSB = 0;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Purpose: combinational CRC32 next-state for one byte (bit 0 of data first).
// Latency: 0 cycles, pure combinational.
// Backpressure: none.
// Ports: data (byte in), crc_in (current register), crc_out (register after data).
module eth_crc32_byte
   import eth_rt_pkg::*;
(
   input  logic [7:0]  data,
   input  logic [31:0] crc_in,
   output logic [31:0] crc_out
);

   logic [31:0] crc_w;

   always_comb begin
      crc_w = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_w[31] ^ data[i]) begin
            crc_w = {crc_w[30:0], 1'b0} ^ CRC_POLY;
         end else begin
            crc_w = {crc_w[30:0], 1'b0};
         end
      end
      crc_out = crc_w;
   end

endmodule

// File: rtl/eth_gmii_tx_framer.sv
// Purpose: GMII transmit framer: preamble/SFD, payload, zero pad, FCS, inter-packet gap.
// Latency: first preamble byte one cycle after sendStart; payload streams byte-per-cycle.
// Backpressure: word_ready throttles the source; a starved byte slot is an underrun (TxErr).
// Ports: clk/rstn; sendStart+byteCount start a frame, abort kills it, clearErrors clears
//        sticky flags; word_* is the payload stream; TxEn/TxD/TxErr drive GMII;
//        busy/frameDone/status report progress and errors.
module eth_gmii_tx_framer
   import eth_rt_pkg::*;
#(
   parameter int WORD_BYTES   = 2,
   parameter int MIN_FRAME    = 64,
   parameter int IPG_BYTES    = 12,
   parameter int PREAMBLE_LEN = 7
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    clearErrors,
   input  logic                    sendStart,
   input  logic [15:0]             byteCount,
   input  logic                    abort,
   input  logic [8*WORD_BYTES-1:0] word_data,
   input  logic                    word_valid,
   output logic                    word_ready,
   output logic                    TxEn,
   output logic [7:0]              TxD,
   output logic                    TxErr,
   output logic                    busy,
   output logic                    frameDone,
   output logic [31:0]             status
);

   localparam int WW  = 8 * WORD_BYTES;
   localparam int WSH = $clog2(WORD_BYTES);
   localparam int SLW = $clog2(WORD_BYTES + 1);
   localparam int PW  = (MIN_FRAME > 0) ? $clog2(MIN_FRAME + 1) : 1;

   tx_state_e      state_q, state_d;
   logic [15:0]    cnt_q, cnt_d;             // preamble / payload / FCS / IPG position
   logic [15:0]    byte_cnt_q, byte_cnt_d;
   logic [15:0]    words_need_q, words_need_d;
   logic [15:0]    words_acc_q, words_acc_d;
   logic [WW-1:0]  hold_q, hold_d;
   logic           hold_vld_q, hold_vld_d;
   logic [WW-1:0]  shf_q, shf_d;
   logic [SLW-1:0] shf_left_q, shf_left_d;
   logic [PW-1:0]  pad_left_q, pad_left_d;
   logic [31:0]    crc_q, crc_d;
   logic [7:0]     frame_cnt_q, frame_cnt_d;
   logic           und_err_q, und_err_d;
   logic           abt_err_q, abt_err_d;
   logic           zl_err_q, zl_err_d;

   logic           shf_empty, hold_take, bypass, accept;
   logic           underrun, abort_hit, zl_set;
   logic [7:0]     pay_byte, crc_byte;
   logic [31:0]    crc_next, fcs_word, pad_need;
   logic [16:0]    wsum, wneed;

   eth_crc32_byte u_crc (
      .data    (crc_byte),
      .crc_in  (crc_q),
      .crc_out (crc_next)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      byte_cnt_d   = byte_cnt_q;
      words_need_d = words_need_q;
      words_acc_d  = words_acc_q;
      hold_d       = hold_q;
      hold_vld_d   = hold_vld_q;
      shf_d        = shf_q;
      shf_left_d   = shf_left_q;
      pad_left_d   = pad_left_q;
      crc_d        = crc_q;
      frame_cnt_d  = frame_cnt_q;
      zl_set       = 1'b0;
      crc_byte     = 8'h00;
      TxEn         = 1'b0;
      TxD          = 8'h00;
      TxErr        = 1'b0;
      frameDone    = 1'b0;

      fcs_word  = ~bitrev32(crc_q);
      pad_need  = 32'(MIN_FRAME - 4) - {16'd0, byte_cnt_q};
      wsum      = {1'b0, byteCount} + 17'(WORD_BYTES - 1);
      wneed     = wsum >> WSH;

      // The next payload byte comes from the shifter, else the holding register,
      // else straight off the bus when both are empty.
      shf_empty = (shf_left_q == '0);
      hold_take = (state_q == S_DATA) && shf_empty && hold_vld_q;
      bypass    = (state_q == S_DATA) && shf_empty && !hold_vld_q;
      if (!shf_empty) begin
         pay_byte = shf_q[7:0];
      end else if (hold_vld_q) begin
         pay_byte = hold_q[7:0];
      end else begin
         pay_byte = word_data[7:0];
      end

      word_ready = ((state_q == S_SFD) || (state_q == S_DATA)) &&
                   (!hold_vld_q || hold_take) && (words_acc_q != words_need_q);
      accept     = word_valid && word_ready;
      underrun   = bypass && !word_valid;
      abort_hit  = abort && (state_q inside {S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS});

      if (accept) begin
         words_acc_d = words_acc_q + 16'd1;
      end
      if (accept && !bypass) begin
         hold_d     = word_data;
         hold_vld_d = 1'b1;
      end else if (hold_take) begin
         hold_vld_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (sendStart) begin
               if (byteCount == 16'd0) begin
                  zl_set = 1'b1;
               end else begin
                  state_d      = S_PREAMBLE;
                  cnt_d        = '0;
                  byte_cnt_d   = byteCount;
                  words_need_d = wneed[15:0];
                  words_acc_d  = '0;
                  hold_vld_d   = 1'b0;
                  shf_left_d   = '0;
                  crc_d        = CRC_INIT;
               end
            end
         end
         S_PREAMBLE: begin
            TxEn = 1'b1;
            TxD  = PREAMBLE_BYTE;
            if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
               state_d = S_SFD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_SFD: begin
            TxEn    = 1'b1;
            TxD     = SFD_BYTE;
            state_d = S_DATA;
            cnt_d   = '0;
         end
         S_DATA: begin
            TxEn     = 1'b1;
            TxD      = pay_byte;
            crc_byte = pay_byte;
            crc_d    = crc_next;
            if (shf_empty) begin
               shf_d      = (hold_vld_q ? hold_q : word_data) >> 8;
               shf_left_d = SLW'(WORD_BYTES - 1);
            end else begin
               shf_d      = shf_q >> 8;
               shf_left_d = shf_left_q - SLW'(1);
            end
            if (cnt_q == byte_cnt_q - 16'd1) begin
               // Tail bytes of the last word are dropped here.
               shf_left_d = '0;
               hold_vld_d = 1'b0;
               cnt_d      = '0;
               if (({16'd0, byte_cnt_q} + 32'd4) < 32'(MIN_FRAME)) begin
                  state_d    = S_PAD;
                  pad_left_d = pad_need[PW-1:0];
               end else begin
                  state_d = S_FCS;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_PAD: begin
            TxEn       = 1'b1;
            TxD        = 8'h00;
            crc_byte   = 8'h00;
            crc_d      = crc_next;
            pad_left_d = pad_left_q - PW'(1);
            if (pad_left_q == PW'(1)) begin
               state_d = S_FCS;
               cnt_d   = '0;
            end
         end
         S_FCS: begin
            TxEn = 1'b1;
            TxD  = fcs_word[8*cnt_q[1:0] +: 8];
            if (cnt_q[1:0] == 2'd3) begin
               frameDone   = 1'b1;
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = S_IPG;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_IPG: begin
            if (cnt_q >= 16'(IPG_BYTES - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A killed frame emits one error byte and goes straight to the gap.
      if (abort_hit || underrun) begin
         TxEn        = 1'b1;
         TxErr       = 1'b1;
         TxD         = 8'h00;
         frameDone   = 1'b0;
         frame_cnt_d = frame_cnt_q;
         crc_d       = crc_q;
         pad_left_d  = pad_left_q;
         hold_vld_d  = 1'b0;
         shf_left_d  = '0;
         state_d     = S_IPG;
         cnt_d       = '0;
      end

      // A flag raised in the same cycle as clearErrors stays set.
      und_err_d = underrun  | (und_err_q & ~clearErrors);
      abt_err_d = abort_hit | (abt_err_q & ~clearErrors);
      zl_err_d  = zl_set    | (zl_err_q  & ~clearErrors);
   end

   always_comb begin
      busy                          = (state_q != S_IDLE);
      status                        = '0;
      status[STAT_UNDERRUN]         = und_err_q;
      status[STAT_ABORT]            = abt_err_q;
      status[STAT_ZERO_LEN]         = zl_err_q;
      status[STAT_FCNT_LSB +: 8]    = frame_cnt_q;
      status[STAT_BCNT_LSB +: 16]   = byte_cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         byte_cnt_q   <= '0;
         words_need_q <= '0;
         words_acc_q  <= '0;
         hold_q       <= '0;
         hold_vld_q   <= 1'b0;
         shf_q        <= '0;
         shf_left_q   <= '0;
         pad_left_q   <= '0;
         crc_q        <= CRC_INIT;
         frame_cnt_q  <= '0;
         und_err_q    <= 1'b0;
         abt_err_q    <= 1'b0;
         zl_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         words_need_q <= words_need_d;
         words_acc_q  <= words_acc_d;
         hold_q       <= hold_d;
         hold_vld_q   <= hold_vld_d;
         shf_q        <= shf_d;
         shf_left_q   <= shf_left_d;
         pad_left_q   <= pad_left_d;
         crc_q        <= crc_d;
         frame_cnt_q  <= frame_cnt_d;
         und_err_q    <= und_err_d;
         abt_err_q    <= abt_err_d;
         zl_err_q     <= zl_err_d;
      end
   end

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Purpose: randomized bench for three framer configurations against a frame-level model.
// Latency: n/a.
// Backpressure: the bench source honours word_ready and can starve on demand.
module tb_eth_gmii_tx_framer;

   localparam int IPG = 12;
   localparam int PRE = 7;
   localparam int NO_STOP = 1 << 30;

   int W_OF[3]   = '{2, 2, 4};
   int MIN_OF[3] = '{0, 64, 64};

   logic        clk;
   logic        rstn;
   logic [2:0]  clr, start, abort_i, wvld;
   logic [15:0] byte_cnt_tb;
   logic [31:0] wdat;
   logic [2:0]  wrdy, txen, txerr, busy, fdone;
   logic [7:0]  txd[3];
   logic [31:0] stat[3];

   int n_chk  = 0;
   int n_pass = 0;

   bit m_und[3], m_abt[3], m_zl[3];
   int m_fc[3], m_bc[3];

   logic [7:0] pay[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   eth_gmii_tx_framer #(.WORD_BYTES(2), .MIN_FRAME(0), .IPG_BYTES(IPG), .PREAMBLE_LEN(PRE)) dut0 (
      .clk(clk), .rstn(rstn), .clearErrors(clr[0]), .sendStart(start[0]), .byteCount(byte_cnt_tb),
      .abort(abort_i[0]), .word_data(wdat[15:0]), .word_valid(wvld[0]), .word_ready(wrdy[0]),
      .TxEn(txen[0]), .TxD(txd[0]), .TxErr(txerr[0]), .busy(busy[0]), .frameDone(fdone[0]),
      .status(stat[0]));

   eth_gmii_tx_framer dut1 (
      .clk(clk), .rstn(rstn), .clearErrors(clr[1]), .sendStart(start[1]), .byteCount(byte_cnt_tb),
      .abort(abort_i[1]), .word_data(wdat[15:0]), .word_valid(wvld[1]), .word_ready(wrdy[1]),
      .TxEn(txen[1]), .TxD(txd[1]), .TxErr(txerr[1]), .busy(busy[1]), .frameDone(fdone[1]),
      .status(stat[1]));

   eth_gmii_tx_framer #(.WORD_BYTES(4), .MIN_FRAME(64), .IPG_BYTES(IPG), .PREAMBLE_LEN(PRE)) dut2 (
      .clk(clk), .rstn(rstn), .clearErrors(clr[2]), .sendStart(start[2]), .byteCount(byte_cnt_tb),
      .abort(abort_i[2]), .word_data(wdat), .word_valid(wvld[2]), .word_ready(wrdy[2]),
      .TxEn(txen[2]), .TxD(txd[2]), .TxErr(txerr[2]), .busy(busy[2]), .frameDone(fdone[2]),
      .status(stat[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Standard reflected CRC-32 over a byte list, returned as the FCS value.
   function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (q[i]) begin
         c = c ^ {24'd0, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic logic [31:0] exp_status(input int s);
      logic [7:0]  fc;
      logic [15:0] bcv;
      fc  = m_fc[s][7:0];
      bcv = m_bc[s][15:0];
      return {m_und[s], m_abt[s], m_zl[s], 5'd0, fc, bcv};
   endfunction

   task automatic fill_random(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
   endtask

   task automatic run_frame(input int sel, input int nbytes, input int stop_words,
                            input int abort_at, input bit poke_ipg, input string tag);
      int wb, nw, npad, trunc, wp, ntx, ipg_seen, err_cnt, err_idx, done_cnt, done_idx, exp_acc;
      bit finished, gap;
      logic [31:0] words[$];
      logic [7:0]  body[$];
      logic [31:0] fcs;

      wb = W_OF[sel];
      nw = (nbytes + wb - 1) / wb;
      for (int w = 0; w < nw; w++) begin
         logic [31:0] v;
         v = $urandom;
         for (int b = 0; b < wb; b++) if (w * wb + b < nbytes) v[8*b +: 8] = pay[w * wb + b];
         words.push_back(v);
      end

      npad = (MIN_OF[sel] > 0 && nbytes + 4 < MIN_OF[sel]) ? MIN_OF[sel] - 4 - nbytes : 0;
      for (int i = 0; i < nbytes; i++) body.push_back(pay[i]);
      for (int i = 0; i < npad; i++) body.push_back(8'h00);
      fcs = fcs_of(body);
      exp_q.delete();
      for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      foreach (body[i]) exp_q.push_back(body[i]);
      for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
      trunc = -1;
      if (stop_words < nw) trunc = PRE + 1 + stop_words * wb;
      if (abort_at >= 0) trunc = abort_at;
      if (trunc >= 0) begin
         while (exp_q.size() > trunc) void'(exp_q.pop_back());
         exp_q.push_back(8'h00);
      end
      exp_acc = (stop_words < nw) ? stop_words : nw;

      @(posedge clk); #1;
      byte_cnt_tb = nbytes[15:0];
      start[sel]  = 1'b1;
      @(posedge clk); #1;
      start[sel]  = 1'b0;

      got_q.delete();
      wp = 0; ntx = 0; ipg_seen = 0; err_cnt = 0; err_idx = -1; done_cnt = 0; done_idx = -1;
      finished = 0; gap = 0;
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
         wvld[sel]    = (wp < nw) && (wp < stop_words);
         wdat         = (wp < nw) ? words[wp] : 32'h0;
         abort_i[sel] = (abort_at >= 0) && (ntx == abort_at);
         start[sel]   = poke_ipg && (ipg_seen == 3);
         @(negedge clk);
         if (txen[sel]) begin
            if (ipg_seen > 0) gap = 1;
            got_q.push_back(txd[sel]);
            if (txerr[sel]) begin err_cnt++; err_idx = ntx; end
            if (fdone[sel]) begin done_cnt++; done_idx = ntx; end
            ntx++;
         end else if (ntx > 0) begin
            if (busy[sel]) ipg_seen++;
            else finished = 1;
         end else begin
            gap = 1;
         end
         if (wvld[sel] && wrdy[sel]) wp++;
         @(posedge clk); #1;
      end
      wvld[sel] = 0; abort_i[sel] = 0; start[sel] = 0;

      check({tag, "_finished"}, 32'(finished), 1);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      check({tag, "_err_cnt"}, err_cnt, (trunc >= 0) ? 1 : 0);
      check({tag, "_err_idx"}, err_idx, trunc);
      check({tag, "_done_cnt"}, done_cnt, (trunc >= 0) ? 0 : 1);
      check({tag, "_done_idx"}, done_idx, (trunc >= 0) ? -1 : exp_q.size() - 1);
      check({tag, "_ipg"}, ipg_seen, IPG);
      check({tag, "_bubble"}, 32'(gap), 0);
      check({tag, "_words"}, wp, exp_acc);

      m_bc[sel] = nbytes;
      if (trunc < 0) m_fc[sel] = (m_fc[sel] + 1) % 256;
      if (stop_words < nw) m_und[sel] = 1;
      if (abort_at >= 0) m_abt[sel] = 1;
      check({tag, "_status"}, stat[sel], exp_status(sel));

      if (poke_ipg) begin
         repeat (3) @(posedge clk);
         @(negedge clk);
         check({tag, "_ipg_start_ignored"}, {30'd0, busy[sel], txen[sel]}, 0);
      end
   endtask

   task automatic clear_errs(input int sel, input string tag);
      @(posedge clk); #1;
      clr[sel] = 1'b1;
      @(posedge clk); #1;
      clr[sel] = 1'b0;
      m_und[sel] = 0; m_abt[sel] = 0; m_zl[sel] = 0;
      @(negedge clk);
      check(tag, stat[sel], exp_status(sel));
   endtask

   initial begin
      rstn = 0; clr = 0; start = 0; abort_i = 0; wvld = 0; byte_cnt_tb = 0; wdat = 0;
      for (int s = 0; s < 3; s++) begin
         m_und[s] = 0; m_abt[s] = 0; m_zl[s] = 0; m_fc[s] = 0; m_bc[s] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rstn = 1;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst%0d_txen", s), {31'd0, txen[s]}, 0);
         check($sformatf("rst%0d_txd", s), {24'd0, txd[s]}, 0);
         check($sformatf("rst%0d_txerr", s), {31'd0, txerr[s]}, 0);
         check($sformatf("rst%0d_busy", s), {31'd0, busy[s]}, 0);
         check($sformatf("rst%0d_ready", s), {31'd0, wrdy[s]}, 0);
         check($sformatf("rst%0d_done", s), {31'd0, fdone[s]}, 0);
         check($sformatf("rst%0d_status", s), stat[s], 0);
      end

      // Known-answer frame "123456789", no padding.
      pay.delete();
      for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
      run_frame(0, 9, NO_STOP, -1, 0, "kat");
      if (got_q.size() >= 21) begin
         check("kat_fcs0", got_q[17], 8'h26);
         check("kat_fcs1", got_q[18], 8'h39);
         check("kat_fcs2", got_q[19], 8'hF4);
         check("kat_fcs3", got_q[20], 8'hCB);
      end else begin
         check("kat_short", got_q.size(), 21);
      end

      // Short frame padded out to the 64-byte minimum.
      fill_random(14);
      run_frame(1, 14, NO_STOP, -1, 0, "pad14");
      check("pad14_txen_cycles", got_q.size(), 72);

      // Long frame on the 4-byte datapath.
      fill_random(100);
      run_frame(2, 100, NO_STOP, -1, 0, "w4_100");

      for (int k = 0; k < 6; k++) begin
         int sel, n;
         sel = $urandom_range(0, 2);
         n   = $urandom_range(1, 90);
         fill_random(n);
         run_frame(sel, n, NO_STOP, -1, 0, $sformatf("rnd%0d", k));
      end

      // Source starves after three words.
      fill_random(20);
      run_frame(1, 20, 3, -1, 0, "und");
      clear_errs(1, "und_clear");

      // Abort on the third FCS byte of a padded frame; a start during the gap is ignored.
      fill_random(30);
      run_frame(1, 30, NO_STOP, PRE + 1 + 60 + 2, 1, "abt");

      // Zero-length request.
      @(posedge clk); #1;
      byte_cnt_tb = 0; start[1] = 1;
      @(posedge clk); #1;
      start[1] = 0;
      m_zl[1] = 1;
      @(negedge clk);
      check("zl_txen", {31'd0, txen[1]}, 0);
      check("zl_busy", {31'd0, busy[1]}, 0);
      check("zl_status", stat[1], exp_status(1));

      // Clear and a fresh zero-length error in the same cycle: the new flag wins.
      @(posedge clk); #1;
      byte_cnt_tb = 0; start[1] = 1; clr[1] = 1;
      @(posedge clk); #1;
      start[1] = 0; clr[1] = 0;
      m_und[1] = 0; m_abt[1] = 0; m_zl[1] = 1;
      @(negedge clk);
      check("clr_vs_set_status", stat[1], exp_status(1));

      // Asynchronous reset in the middle of payload.
      @(posedge clk); #1;
      byte_cnt_tb = 16'd50; start[2] = 1;
      @(posedge clk); #1;
      start[2] = 0;
      for (int i = 0; i < 15; i++) begin
         wvld[2] = 1; wdat = $urandom;
         @(posedge clk); #1;
      end
      check("midrst_pre_txen", {31'd0, txen[2]}, 1);
      #1 rstn = 0;
      #1;
      check("midrst_txen", {31'd0, txen[2]}, 0);
      check("midrst_status", stat[2], 0);
      check("midrst_busy", {31'd0, busy[2]}, 0);
      wvld[2] = 0;
      @(posedge clk); #1 rstn = 1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/eth_gmii_tx_framer.md
Name: eth_gmii_tx_framer

Overview:
Parametrised GMII transmit framer for the real-time Ethernet path on FPGA V3. It sits between EthernetIO (word source) and the Ethernet switch/PHY (byte sink).
- Takes WORD_BYTES-wide words over a valid/ready stream and emits preamble/SFD, payload bytes, zero padding, FCS and the inter-packet gap.
- Adds over the previous generation: configurable word width, minimum frame size and IPG; underrun detection; abort; a sticky status register.

Parameters:
WORD_BYTES, 2, bytes per input word (2 or 4); byte 0 = word[7:0], sent first
MIN_FRAME, 64, minimum frame length in bytes including FCS; 0 disables padding
IPG_BYTES, 12, idle cycles enforced after FCS before next frame may start
PREAMBLE_LEN, 7, number of 0x55 bytes before SFD 0xD5

Ports:
clk  in  1  clock, one byte per cycle on GMII
rstn  in  1  asynchronous active-low reset
clearErrors  in  1  clears sticky error flags
sendStart  in  1  pulse: begin frame; sampled only in IDLE
byteCount  in  16  payload bytes (dest MAC onward, excluding FCS); latched at sendStart
abort  in  1  terminate current frame
word_data  in  8*WORD_BYTES  payload word
word_valid  in  1  word_data valid
word_ready  out  1  framer accepts word this cycle
TxEn  out  1  GMII transmit enable
TxD  out  8  GMII data
TxErr  out  1  GMII error
busy  out  1  high from sendStart accepted until IPG complete
frameDone  out  1  one-cycle pulse when last FCS byte leaves
status  out  32  {underrunErr, abortErr, zeroLenErr, 5'd0, frameCnt[7:0], 16'd0 lastByteCount}

Behaviour:
- Reset: all outputs 0, state IDLE, CRC reg 0xFFFFFFFF, flags/counters 0.
- States and transitions:
  - IDLE:
    - sendStart with byteCount!=0 -> PREAMBLE; TxEn=1, TxD=0x55 on next cycle (latency 1).
    - byteCount==0 -> set zeroLenErr, stay IDLE, busy stays 0.
  - PREAMBLE: PREAMBLE_LEN cycles of 0x55, then one cycle of 0xD5 -> DATA.
  - DATA:
    - Emits payload bytes with no bubbles while word_valid is held high.
    - 1-entry holding register plus byte shifter. word_ready=1 when the holding register is empty or being emptied this cycle, and fewer than ceil(byteCount/WORD_BYTES) words have been accepted. Prefetch starts during the SFD cycle.
    - Unused tail bytes of the last word are discarded.
    - Last payload byte -> PAD if (byteCount+4)<MIN_FRAME, else FCS.
  - PAD: TxD=0x00 until total byteCount+pad = MIN_FRAME-4 -> FCS.
  - FCS:
    - 4 bytes: complemented, bit-reversed CRC32 (poly 0x04C11DB7), LSB byte first.
    - CRC covers payload and pad bytes only.
    - Last byte: frameDone=1, frameCnt+1 (wraps at 255) -> IPG.
  - IPG: TxEn=0 for IPG_BYTES cycles; sendStart ignored; busy=1 -> IDLE.
- Underrun: in DATA, a byte is needed and the holding register is empty with word_valid=0.
  - That cycle: TxEn=1, TxErr=1, TxD=0x00.
  - Set underrunErr; go to IPG; no FCS; no frameDone.
- Abort in PREAMBLE/DATA/PAD/FCS: same as underrun but sets abortErr. Abort in IDLE or IPG is ignored.
- Abort and underrun in the same cycle: both flags set.
- clearErrors clears the three flags. A flag set in the same cycle as clearErrors wins (stays set).
- sendStart while busy: ignored, no flag.
- rstn asserted mid-frame: TxEn drops immediately (async). Words already accepted are lost. The source must restart.
- Payload byte count is a 16-bit compare; the pad counter is sized clog2(MIN_FRAME+1).

Decomposition:
- Shared package eth_rt_pkg:
  - state enum
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5
  - CRC_INIT 32'hFFFFFFFF, CRC_RESIDUE
  - status bit positions
- Sub-module eth_crc32_byte: combinational 8-bit-per-cycle CRC32 next-state (data, crc_in -> crc_out). It is reused by the future receive checker.

Test Plan:
- MIN_FRAME=0, WORD_BYTES=2, byteCount=9, words 0x3231,0x3433,0x3635,0x3837,0x0039 ("123456789") -> TxD: 7x55, D5, 31..39, then 26 39 F4 CB. frameDone on the CB cycle, then 12 idle cycles.
- Default params, byteCount=14 -> 14 payload bytes, 46 zero pad bytes, 4 FCS bytes; TxEn high for 72 cycles total.
- WORD_BYTES=4, byteCount=100, word_valid held high -> 100 consecutive payload bytes with no gap; exactly 25 words accepted.
- word_valid deasserted after 3 words (byteCount=20, W=2) -> TxErr=1 at payload byte 6; status[31]=1; no FCS; clearErrors -> status[31]=0.
- abort asserted on FCS byte 2 -> TxErr pulse, abortErr=1, frameCnt unchanged. sendStart during the following IPG is ignored.
- sendStart with byteCount=0 -> TxEn stays 0, zeroLenErr=1. rstn low mid-DATA -> TxEn=0 and status=0 immediately.
